// File: rtl/quad_encoder_array_if.sv
// Pad-side / core-side signal bundle for quad_encoder_array.
// The slave modport is the encoder front end; the master modport is whoever
// drives the encoder pins and consumes the positions.
interface quad_encoder_array_if #(
    parameter int CHANNELS = 2,
    parameter int POSWIDTH = 5
);
    logic [CHANNELS-1:0]          enc_a;
    logic [CHANNELS-1:0]          enc_b;
    logic                         enable;
    logic [CHANNELS-1:0]          clear;
    logic [CHANNELS*POSWIDTH-1:0] pos;
    logic [CHANNELS-1:0]          step;
    logic [CHANNELS-1:0]          dir;
    logic [CHANNELS-1:0]          err;

    modport master (
        output enc_a, enc_b, enable, clear,
        input  pos, step, dir, err
    );

    modport slave (
        input  enc_a, enc_b, enable, clear,
        output pos, step, dir, err
    );
endinterface

// File: rtl/quad_encoder_array.sv
// quad_encoder_array: CHANNELS independent quadrature encoder front ends.
// Per channel: 2-flop synchroniser per phase, per-phase debounce, x4 Gray
// decode and a bounded (saturating or wrapping) position counter.
// Optional feature macro: QUAD_ERR_EN -- when defined, err[i] is a sticky
// illegal-transition flag; when undefined, err is tied to 0.
module quad_encoder_array #(
    parameter int CHANNELS      = 2,
    parameter int DEBOUNCEWIDTH = 2,
    parameter int POSWIDTH      = 5,
    parameter int POS_MAX       = 31,
    parameter int POS_INIT      = 15,
    parameter int WRAP          = 0
) (
    input  logic                 clock,
    input  logic                 resetb,
    quad_encoder_array_if.slave  bus
);

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2,
        STEP_ILL  = 2'd3
    } step_e;

    localparam logic [DEBOUNCEWIDTH-1:0] CNT_MAX  = '1;
    // Level is accepted on the edge where the 2**DEBOUNCEWIDTH-th matching sample is seen.
    localparam logic [DEBOUNCEWIDTH-1:0] CNT_LAST = DEBOUNCEWIDTH'(2**DEBOUNCEWIDTH - 2);
    localparam logic [POSWIDTH-1:0]      P_MAX    = POSWIDTH'(POS_MAX);
    localparam logic [POSWIDTH-1:0]      P_INIT   = POSWIDTH'(POS_INIT);

    // {a,b}: 00 -> 01 -> 11 -> 10 -> 00 counts up; both bits flipping is illegal.
    function automatic step_e gray_decode(input logic [1:0] prv, input logic [1:0] cur);
        step_e res;
        if (prv == cur) begin
            res = STEP_NONE;
        end else if ((prv ^ cur) == 2'b11) begin
            res = STEP_ILL;
        end else begin
            case ({prv, cur})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: res = STEP_UP;
                default:                            res = STEP_DN;
            endcase
        end
        return res;
    endfunction

    // Returns {moved, new_pos}; at POS_MAX either wraps to 0 or holds.
    function automatic logic [POSWIDTH:0] pos_up(input logic [POSWIDTH-1:0] p);
        logic [POSWIDTH:0] res;
        if (p == P_MAX) begin
            res = (WRAP != 0) ? {1'b1, {POSWIDTH{1'b0}}} : {1'b0, p};
        end else begin
            res = {1'b1, p + 1'b1};
        end
        return res;
    endfunction

    // Returns {moved, new_pos}; at 0 either wraps to POS_MAX or holds.
    function automatic logic [POSWIDTH:0] pos_dn(input logic [POSWIDTH-1:0] p);
        logic [POSWIDTH:0] res;
        if (p == '0) begin
            res = (WRAP != 0) ? {1'b1, P_MAX} : {1'b0, p};
        end else begin
            res = {1'b1, p - 1'b1};
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        // Bit 1 carries phase A, bit 0 phase B throughout.
        logic [1:0]               r_sync1;
        logic [1:0]               r_sync2;
        logic [1:0]               r_cand;
        logic [1:0]               r_lvl;
        logic [1:0]               r_settled;
        logic [DEBOUNCEWIDTH-1:0] r_cnt [2];
        logic [1:0]               r_prev;
        logic                     r_primed;
        logic [POSWIDTH-1:0]      r_pos;
        logic                     r_step;
        logic                     r_dir;
        step_e                    w_code;
        logic                     w_up;
        logic                     w_dn;
        logic [POSWIDTH:0]        w_up_res;
        logic [POSWIDTH:0]        w_dn_res;

        // Synchronise both phases and debounce each one independently.
        always_ff @(posedge clock or negedge resetb) begin
            if (!resetb) begin
                r_sync1   <= '0;
                r_sync2   <= '0;
                r_cand    <= '0;
                r_lvl     <= '0;
                r_settled <= '0;
                for (int p = 0; p < 2; p++) begin
                    r_cnt[p] <= '0;
                end
            end else begin
                r_sync1 <= {bus.enc_a[gi], bus.enc_b[gi]};
                r_sync2 <= r_sync1;
                for (int p = 0; p < 2; p++) begin
                    if (r_sync2[p] != r_cand[p]) begin
                        r_cand[p] <= r_sync2[p];
                        r_cnt[p]  <= '0;
                    end else if (r_cnt[p] != CNT_MAX) begin
                        r_cnt[p] <= r_cnt[p] + 1'b1;
                        if (r_cnt[p] == CNT_LAST) begin
                            r_lvl[p]     <= r_cand[p];
                            r_settled[p] <= 1'b1;
                        end
                    end
                end
            end
        end

        assign w_code   = gray_decode(r_prev, r_lvl);
        assign w_up     = r_primed && (w_code == STEP_UP);
        assign w_dn     = r_primed && (w_code == STEP_DN);
        assign w_up_res = pos_up(r_pos);
        assign w_dn_res = pos_dn(r_pos);

        // Prime on the first debounced state, then decode and update the position.
        always_ff @(posedge clock or negedge resetb) begin
            if (!resetb) begin
                r_prev   <= '0;
                r_primed <= 1'b0;
                r_pos    <= P_INIT;
                r_step   <= 1'b0;
                r_dir    <= 1'b0;
            end else begin
                r_step <= 1'b0;
                if (r_primed || (&r_settled)) begin
                    r_prev   <= r_lvl;
                    r_primed <= 1'b1;
                end
                if (bus.clear[gi]) begin
                    r_pos <= P_INIT;
                end else if (bus.enable && w_up) begin
                    r_dir  <= 1'b1;
                    r_pos  <= w_up_res[POSWIDTH-1:0];
                    r_step <= w_up_res[POSWIDTH];
                end else if (bus.enable && w_dn) begin
                    r_dir  <= 1'b0;
                    r_pos  <= w_dn_res[POSWIDTH-1:0];
                    r_step <= w_dn_res[POSWIDTH];
                end
            end
        end

`ifdef QUAD_ERR_EN
        logic r_err;

        // Sticky illegal-transition flag, cleared only by clear or reset.
        always_ff @(posedge clock or negedge resetb) begin
            if (!resetb) begin
                r_err <= 1'b0;
            end else if (bus.clear[gi]) begin
                r_err <= 1'b0;
            end else if (r_primed && (w_code == STEP_ILL)) begin
                r_err <= 1'b1;
            end
        end

        assign bus.err[gi] = r_err;
`else
        assign bus.err[gi] = 1'b0;
`endif

        assign bus.pos[gi*POSWIDTH +: POSWIDTH] = r_pos;
        assign bus.step[gi]                     = r_step;
        assign bus.dir[gi]                      = r_dir;
    end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Directed bench for quad_encoder_array (defaults, plus a 1-channel WRAP=1
// instance that mirrors channel 0's inputs). Honours QUAD_ERR_EN.
module tb_quad_encoder_array;

    localparam int CH = 2;
    localparam int PW = 5;
`ifdef QUAD_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clock  = 1'b0;
    logic resetb = 1'b0;
    always #5 clock = ~clock;

    quad_encoder_array_if #(.CHANNELS(CH), .POSWIDTH(PW)) bus ();
    quad_encoder_array_if #(.CHANNELS(1),  .POSWIDTH(PW)) wbus ();

    quad_encoder_array #(
        .CHANNELS(CH), .DEBOUNCEWIDTH(2), .POSWIDTH(PW),
        .POS_MAX(31), .POS_INIT(15), .WRAP(0)
    ) dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (bus)
    );

    quad_encoder_array #(
        .CHANNELS(1), .DEBOUNCEWIDTH(2), .POSWIDTH(PW),
        .POS_MAX(31), .POS_INIT(15), .WRAP(1)
    ) dut_w (
        .clock  (clock),
        .resetb (resetb),
        .bus    (wbus)
    );

    assign wbus.enc_a  = bus.enc_a[0:0];
    assign wbus.enc_b  = bus.enc_b[0:0];
    assign wbus.enable = bus.enable;
    assign wbus.clear  = bus.clear[0:0];

    int passed = 0;
    int total  = 0;
    int sc0 = 0, sc1 = 0, scw = 0;
    logic [1:0] st [CH];

    // Count step pulses away from the active edge.
    always @(negedge clock) begin
        if (bus.step[0] === 1'b1) sc0++;
        if (bus.step[1] === 1'b1) sc1++;
        if (wbus.step[0] === 1'b1) scw++;
    end

    function automatic logic [PW-1:0] pos_of(input int ch);
        return bus.pos[ch*PW +: PW];
    endfunction

    function automatic logic [1:0] gnext(input logic [1:0] ab, input bit up);
        logic [1:0] r;
        case (ab)
            2'b00:   r = up ? 2'b01 : 2'b10;
            2'b01:   r = up ? 2'b11 : 2'b00;
            2'b11:   r = up ? 2'b10 : 2'b01;
            default: r = up ? 2'b00 : 2'b11;
        endcase
        return r;
    endfunction

    task automatic set_ab(input int ch, input logic [1:0] ab);
        bus.enc_a[ch] = ab[1];
        bus.enc_b[ch] = ab[0];
        st[ch] = ab;
    endtask

    task automatic move(input int ch, input bit up, input int hold);
        set_ab(ch, gnext(st[ch], up));
        repeat (hold) @(negedge clock);
    endtask

    task automatic pulse_clear(input logic [CH-1:0] m);
        bus.clear = m;
        @(negedge clock);
        bus.clear = '0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        total++; if (bus.pos !== {5'd15, 5'd15}) $display("FAIL rst_pos: got %h want %h", bus.pos, {5'd15, 5'd15}); else passed++;
        total++; if (bus.step !== 2'b00) $display("FAIL rst_step: got %b want 00", bus.step); else passed++;
        total++; if (bus.dir !== 2'b00) $display("FAIL rst_dir: got %b want 00", bus.dir); else passed++;
        total++; if (bus.err !== 2'b00) $display("FAIL rst_err: got %b want 00", bus.err); else passed++;
        resetb = 1'b1;
        repeat (20) @(negedge clock);
        total++; if (bus.pos !== {5'd15, 5'd15}) $display("FAIL prime_pos: got %h want %h", bus.pos, {5'd15, 5'd15}); else passed++;
        total++; if (wbus.pos !== 5'd15) $display("FAIL prime_wpos: got %0d want 15", wbus.pos); else passed++;
        total++; if (sc0 + sc1 + scw !== 0) $display("FAIL prime_steps: got %0d want 0", sc0 + sc1 + scw); else passed++;
        total++; if (bus.err !== 2'b00) $display("FAIL prime_err: got %b want 00", bus.err); else passed++;
    endtask

    task automatic test_up();
        int b0;
        b0 = sc0;
        set_ab(0, 2'b10);
        repeat (6) @(posedge clock);
        #1;
        total++; if (bus.step[0] !== 1'b0 || pos_of(0) !== 5'd15) $display("FAIL lat_early: step=%b pos=%0d want 0/15", bus.step[0], pos_of(0)); else passed++;
        @(posedge clock);
        #1;
        total++; if (bus.step[0] !== 1'b1 || pos_of(0) !== 5'd16) $display("FAIL lat_edge7: step=%b pos=%0d want 1/16", bus.step[0], pos_of(0)); else passed++;
        @(posedge clock);
        #1;
        total++; if (bus.step[0] !== 1'b0) $display("FAIL step_width: got %b want 0", bus.step[0]); else passed++;
        @(negedge clock);
        repeat (3) move(0, 1'b1, 8);
        total++; if (pos_of(0) !== 5'd19) $display("FAIL up_pos0: got %0d want 19", pos_of(0)); else passed++;
        total++; if (sc0 - b0 !== 4) $display("FAIL up_pulses: got %0d want 4", sc0 - b0); else passed++;
        total++; if (bus.dir[0] !== 1'b1) $display("FAIL up_dir0: got %b want 1", bus.dir[0]); else passed++;
        total++; if (pos_of(1) !== 5'd15) $display("FAIL up_pos1: got %0d want 15", pos_of(1)); else passed++;
        total++; if (sc1 !== 0) $display("FAIL up_ch1_steps: got %0d want 0", sc1); else passed++;
    endtask

    task automatic test_glitch();
        int b0;
        b0 = sc0;
        bus.enc_a[0] = ~st[0][1];
        repeat (3) @(negedge clock);
        bus.enc_a[0] = st[0][1];
        repeat (12) @(negedge clock);
        total++; if (pos_of(0) !== 5'd19) $display("FAIL glitch_pos: got %0d want 19", pos_of(0)); else passed++;
        total++; if (sc0 !== b0) $display("FAIL glitch_steps: got %0d want %0d", sc0, b0); else passed++;
    endtask

    task automatic test_saturate();
        int b0, bw;
        pulse_clear(2'b01);
        total++; if (pos_of(0) !== 5'd15 || wbus.pos !== 5'd15) $display("FAIL sat_clr: pos0=%0d wpos=%0d want 15/15", pos_of(0), wbus.pos); else passed++;
        b0 = sc0;
        bw = scw;
        repeat (15) move(0, 1'b0, 8);
        total++; if (pos_of(0) !== 5'd0) $display("FAIL sat_pos0: got %0d want 0", pos_of(0)); else passed++;
        total++; if (wbus.pos !== 5'd0) $display("FAIL wrap_at0: got %0d want 0", wbus.pos); else passed++;
        total++; if (sc0 - b0 !== 15) $display("FAIL sat_pulses15: got %0d want 15", sc0 - b0); else passed++;
        move(0, 1'b0, 8);
        total++; if (pos_of(0) !== 5'd0) $display("FAIL sat_hold: got %0d want 0", pos_of(0)); else passed++;
        total++; if (wbus.pos !== 5'd31) $display("FAIL wrap_under: got %0d want 31", wbus.pos); else passed++;
        total++; if (scw - bw !== 16) $display("FAIL wrap_pulses: got %0d want 16", scw - bw); else passed++;
        repeat (4) move(0, 1'b0, 8);
        total++; if (pos_of(0) !== 5'd0 || sc0 - b0 !== 15) $display("FAIL sat_final: pos0=%0d pulses=%0d want 0/15", pos_of(0), sc0 - b0); else passed++;
        total++; if (bus.dir[0] !== 1'b0) $display("FAIL sat_dir: got %b want 0", bus.dir[0]); else passed++;
        total++; if (wbus.pos !== 5'd27) $display("FAIL wrap_final: got %0d want 27", wbus.pos); else passed++;
    endtask

    task automatic test_illegal();
        int b1;
        b1 = sc1;
        repeat (2) move(1, 1'b1, 8);
        total++; if (pos_of(1) !== 5'd17) $display("FAIL ill_pre: got %0d want 17", pos_of(1)); else passed++;
        set_ab(1, 2'b11);
        repeat (12) @(negedge clock);
        total++; if (pos_of(1) !== 5'd17 || sc1 - b1 !== 2) $display("FAIL ill_nostep: pos1=%0d pulses=%0d want 17/2", pos_of(1), sc1 - b1); else passed++;
        total++; if (bus.err[1] !== ERR_EN) $display("FAIL ill_err1: got %b want %b", bus.err[1], ERR_EN); else passed++;
        total++; if (bus.err[0] !== 1'b0) $display("FAIL ill_err0: got %b want 0", bus.err[0]); else passed++;
        pulse_clear(2'b10);
        total++; if (bus.err[1] !== 1'b0 || pos_of(1) !== 5'd15) $display("FAIL ill_clear: err1=%b pos1=%0d want 0/15", bus.err[1], pos_of(1)); else passed++;
    endtask

    task automatic test_enable_clear();
        int b0;
        pulse_clear(2'b01);
        b0 = sc0;
        bus.enable = 1'b0;
        repeat (3) move(0, 1'b1, 8);
        total++; if (pos_of(0) !== 5'd15 || sc0 !== b0) $display("FAIL en_off: pos0=%0d pulses=%0d want 15/0", pos_of(0), sc0 - b0); else passed++;
        bus.enable = 1'b1;
        repeat (10) @(negedge clock);
        total++; if (pos_of(0) !== 5'd15 || wbus.pos !== 5'd15) $display("FAIL en_nocatch: pos0=%0d wpos=%0d want 15/15", pos_of(0), wbus.pos); else passed++;
        move(0, 1'b1, 8);
        total++; if (pos_of(0) !== 5'd16 || sc0 - b0 !== 1) $display("FAIL en_resume: pos0=%0d pulses=%0d want 16/1", pos_of(0), sc0 - b0); else passed++;
        set_ab(0, gnext(st[0], 1'b1));
        repeat (6) @(posedge clock);
        @(negedge clock);
        bus.clear = 2'b01;
        @(posedge clock);
        #1;
        total++; if (pos_of(0) !== 5'd15 || bus.step[0] !== 1'b0) $display("FAIL clr_wins: pos0=%0d step=%b want 15/0", pos_of(0), bus.step[0]); else passed++;
        @(negedge clock);
        bus.clear = '0;
        repeat (4) @(negedge clock);
        total++; if (pos_of(0) !== 5'd15 || sc0 - b0 !== 1) $display("FAIL clr_after: pos0=%0d pulses=%0d want 15/1", pos_of(0), sc0 - b0); else passed++;
    endtask

    task automatic test_simultaneous();
        int b0, b1;
        b0 = sc0;
        b1 = sc1;
        set_ab(0, gnext(st[0], 1'b1));
        set_ab(1, gnext(st[1], 1'b1));
        repeat (8) @(negedge clock);
        total++; if (pos_of(0) !== 5'd16 || pos_of(1) !== 5'd16) $display("FAIL sim_pos: pos0=%0d pos1=%0d want 16/16", pos_of(0), pos_of(1)); else passed++;
        total++; if (sc0 - b0 !== 1 || sc1 - b1 !== 1) $display("FAIL sim_pulses: %0d/%0d want 1/1", sc0 - b0, sc1 - b1); else passed++;
    endtask

    task automatic test_reset_mid();
        int b0;
        set_ab(0, gnext(st[0], 1'b0));
        repeat (4) @(negedge clock);
        resetb = 1'b0;
        #1;
        total++; if (bus.pos !== {5'd15, 5'd15} || bus.step !== 2'b00) $display("FAIL mid_rst: pos=%h step=%b want %h/00", bus.pos, bus.step, {5'd15, 5'd15}); else passed++;
        @(negedge clock);
        b0 = sc0;
        resetb = 1'b1;
        repeat (20) @(negedge clock);
        total++; if (pos_of(0) !== 5'd15 || sc0 !== b0) $display("FAIL mid_reprime: pos0=%0d pulses=%0d want 15/0", pos_of(0), sc0 - b0); else passed++;
        total++; if (bus.dir !== 2'b00 || bus.err !== 2'b00) $display("FAIL mid_flags: dir=%b err=%b want 00/00", bus.dir, bus.err); else passed++;
    endtask

    initial begin
        bus.enc_a  = '1;
        bus.enc_b  = '1;
        bus.enable = 1'b1;
        bus.clear  = '0;
        for (int i = 0; i < CH; i++) st[i] = 2'b11;
        repeat (2) @(negedge clock);
        test_reset();
        test_up();
        test_glitch();
        test_saturate();
        test_illegal();
        test_enable_clear();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
